hazard_stall_ctrl: RTL

Pipeline interlock controller for the five-stage MIPS core; it produces the `Stall` input consumed by the fetch unit and the bubble control for the ID/EX register. It keeps its own shadow pipeline of destination registers and result-ready times for E and M, so it decides stalls from D-stage decode information alone. It also owns the multiply/divide busy counter, which interlocks HI/LO instructions. All forwarding that does not require a stall is handled elsewhere; this block only decides stall versus no stall.

---
 rtl/hazard_stall_ctrl_pkg.sv | 35 +++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings, defaults and the register-hazard compare for the
// pipeline interlock controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic       start;
    logic       div;
  } e_shadow_t;

  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
  } m_shadow_t;

  // Tnew never exceeds 2, so a Tuse of 3 can never satisfy tuse < tnew.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input e_shadow_t  e,
                                      input m_shadow_t  m);
    return (src != 5'd0) &&
           ((src == e.waddr && tuse < e.tnew) ||
            (src == m.waddr && tuse < m.tnew));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter: loads the unit latency when an op sits
// in E, then counts down to zero; busy covers the start cycle plus the count.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div,
  output logic       busy,
  output logic [3:0] cnt
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start | (cnt_q != 4'd0);
  assign cnt  = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: shadows destination/Tnew for E and M, compares against
// D-stage sources, and interlocks HI/LO users against the mult/div unit.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] waddr_D,
  input  logic [1:0] tnew_D,
  input  logic       md_use_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  output logic       Stall,
  output logic       clr_E,
  output logic       md_busy
);

  e_shadow_t  e_q, e_d;
  m_shadow_t  m_q, m_d;
  logic [3:0] md_cnt;
  logic       hz_rs, hz_rt, hz_md;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk  (clk),
    .reset(reset),
    .start(e_q.start),
    .div  (e_q.div),
    .busy (md_busy),
    .cnt  (md_cnt)
  );

  always_comb begin
    hz_rs = src_hazard(rs_D, tuse_rs_D, e_q, m_q);
    hz_rt = src_hazard(rt_D, tuse_rt_D, e_q, m_q);
    hz_md = md_use_D & md_busy;
    Stall = ~reset & (hz_rs | hz_rt | hz_md);
    clr_E = reset | Stall;
  end

  // A stalled D instruction is replaced by a bubble, so a held mult/div
  // cannot start the unit until the edge on which it actually advances.
  always_comb begin
    e_d = '0;
    if (!Stall) begin
      e_d.waddr = waddr_D;
      e_d.tnew  = tnew_D;
      e_d.start = md_start_D;
      e_d.div   = md_div_D;
    end
    m_d.waddr = e_q.waddr;
    m_d.tnew  = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  a_md_busy_consistent: assert property (@(posedge clk) disable iff (reset)
    md_busy == (e_q.start || md_cnt != 4'd0));

endmodule
